adc_speed_sampler: RTL

//   Upstream of the VGA game controller. Paces the external ADC:
//   - issues periodic conversion-start pulses;
//   - waits for end-of-conversion and captures the 8-bit result;
//   - averages 2^AVG_LOG2 samples and applies a dead zone.
//   The result is a stable move_speed, consumed once per frame as the

---
 rtl/adc_pkg.sv | 24 ++
 rtl/adc_speed_sampler_if.sv | 29 ++
 rtl/sync2.sv | 21 ++
 rtl/adc_speed_sampler.sv | 130 +++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and default timing for the ADC pacing/filter block.
package adc_pkg;

    localparam int unsigned ADC_DATA_W = 8;

    localparam int unsigned DEF_SAMPLE_PERIOD      = 100000;
    localparam int unsigned DEF_START_PULSE_CYCLES = 4;
    localparam int unsigned DEF_EOC_TIMEOUT        = 10000;
    localparam int unsigned DEF_AVG_LOG2           = 2;
    localparam int unsigned DEF_DEAD_ZONE          = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_EOC = 2'd2,
        CAPTURE  = 2'd3
    } state_t;

    // Bits needed to hold a counter running 0..n-1 (never less than one).
    function automatic int unsigned cntWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_speed_sampler_if.sv
// ADC handshake plus filtered speed outputs of the sampler.
interface adc_speed_sampler_if;

    logic                          eoc;
    logic [adc_pkg::ADC_DATA_W-1:0] adc_data;
    logic                          adc_start;
    logic [adc_pkg::ADC_DATA_W-1:0] move_speed;
    logic                          speed_valid;
    logic                          timeout_err;

    modport master (
        input  eoc,
        input  adc_data,
        output adc_start,
        output move_speed,
        output speed_valid,
        output timeout_err
    );

    modport slave (
        output eoc,
        output adc_data,
        input  adc_start,
        input  move_speed,
        input  speed_valid,
        input  timeout_err
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser with synchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_speed_sampler.sv
// Paces ADC conversions, averages 2^AVG_LOG2 results and applies a dead zone
// to produce a stable move_speed for the game controller.
module adc_speed_sampler
    import adc_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD      = DEF_SAMPLE_PERIOD,
    parameter int unsigned START_PULSE_CYCLES = DEF_START_PULSE_CYCLES,
    parameter int unsigned EOC_TIMEOUT        = DEF_EOC_TIMEOUT,
    parameter int unsigned AVG_LOG2           = DEF_AVG_LOG2,
    parameter int unsigned DEAD_ZONE          = DEF_DEAD_ZONE
) (
    input  logic                 clk,
    input  logic                 reset,
    adc_speed_sampler_if.master  bus
);

    localparam int unsigned ACC_W   = ADC_DATA_W + AVG_LOG2;
    localparam int unsigned CNT_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned PER_W   = cntWidth(SAMPLE_PERIOD);
    localparam int unsigned PULSE_W = cntWidth(START_PULSE_CYCLES);
    localparam int unsigned TO_W    = cntWidth(EOC_TIMEOUT);

    state_t               state, stateNext;
    logic [PER_W-1:0]     perCnt;
    logic [PULSE_W-1:0]   pulseCnt, pulseCntNext;
    logic [TO_W-1:0]      toCnt, toCntNext;
    logic [ACC_W-1:0]     acc, accNext;
    logic [CNT_W-1:0]     cnt, cntNext;
    logic [ACC_W-1:0]     sum, avg;
    logic [ADC_DATA_W-1:0] speedNext;
    logic                 startNext, validNext, errNext;
    logic                 eocSync, eocSyncD, eocRise;

    sync2 u_eocSync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.eoc),
        .q     (eocSync)
    );

    // Next-state and next-output decode.
    always_comb begin
        stateNext    = state;
        pulseCntNext = pulseCnt;
        toCntNext    = toCnt;
        accNext      = acc;
        cntNext      = cnt;
        speedNext    = bus.move_speed;
        validNext    = 1'b0;
        errNext      = bus.timeout_err;
        sum          = acc + ACC_W'(bus.adc_data);
        avg          = sum >> AVG_LOG2;

        case (state)
            IDLE: begin
                if (perCnt == PER_W'(SAMPLE_PERIOD - 1)) begin
                    stateNext    = START;
                    pulseCntNext = '0;
                end
            end
            START: begin
                if (pulseCnt == PULSE_W'(START_PULSE_CYCLES - 1)) begin
                    stateNext = WAIT_EOC;
                    toCntNext = '0;
                end else begin
                    pulseCntNext = pulseCnt + PULSE_W'(1);
                end
            end
            WAIT_EOC: begin
                // Only a fresh edge counts; a level already high on entry never rises.
                if (eocRise) begin
                    stateNext = CAPTURE;
                end else if (toCnt == TO_W'(EOC_TIMEOUT - 1)) begin
                    stateNext = IDLE;
                    errNext   = 1'b1;
                end else begin
                    toCntNext = toCnt + TO_W'(1);
                end
            end
            CAPTURE: begin
                stateNext = IDLE;
                errNext   = 1'b0;
                if (cnt == CNT_W'((1 << AVG_LOG2) - 1)) begin
                    accNext   = '0;
                    cntNext   = '0;
                    speedNext = (avg < ACC_W'(DEAD_ZONE)) ? '0 : ADC_DATA_W'(avg);
                    validNext = 1'b1;
                end else begin
                    accNext = sum;
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase

        startNext = (stateNext == START);
    end

    // State, counters, edge detector and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            perCnt          <= '0;
            pulseCnt        <= '0;
            toCnt           <= '0;
            acc             <= '0;
            cnt             <= '0;
            eocSyncD        <= 1'b0;
            eocRise         <= 1'b0;
            bus.adc_start   <= 1'b0;
            bus.move_speed  <= '0;
            bus.speed_valid <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            state           <= stateNext;
            perCnt          <= (perCnt == PER_W'(SAMPLE_PERIOD - 1)) ? '0 : perCnt + PER_W'(1);
            pulseCnt        <= pulseCntNext;
            toCnt           <= toCntNext;
            acc             <= accNext;
            cnt             <= cntNext;
            eocSyncD        <= eocSync;
            eocRise         <= eocSync & ~eocSyncD;
            bus.adc_start   <= startNext;
            bus.move_speed  <= speedNext;
            bus.speed_valid <= validNext;
            bus.timeout_err <= errNext;
        end
    end

endmodule
